// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract accumulator stage.
// Saturation limits are used only when ACC_SATURATE_EN is defined.
package addsub_pkg;

  localparam int ACC_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Largest and smallest signed values representable in w bits.
  function automatic logic [63:0] sat_max(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit two's-complement add/subtract with signed overflow detect.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic             carry_into_msb;

  assign b_eff = b ^ {WIDTH{sub}};
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  // The MSB sum bit is a ^ b ^ carry-in, so the carry into it can be recovered.
  assign carry_into_msb = full[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];

  assign sum = full[WIDTH-1:0];
  assign ovf = carry_into_msb ^ full[WIDTH];

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulates a stream of signed add/sub operands and presents total, sticky overflow and beat count.
// Define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] core_sum;
  logic             core_ovf;
  logic [WIDTH-1:0] step_sum;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a   (acc_q),
    .b   (in_data),
    .sub (in_sub),
    .sum (core_sum),
    .ovf (core_ovf)
  );

`ifdef ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

  // An overflowing step always moves away from the pre-step sign, so that sign picks the rail.
  assign step_sum = core_ovf ? (acc_q[WIDTH-1] ? SAT_LO : SAT_HI) : core_sum;
`else
  assign step_sum = core_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (in_valid) begin
          acc_d = step_sum;
          ovf_d = ovf_q | core_ovf;
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
          state_d = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule
